// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, lengths and helpers for the instruction-fetch PC unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
    localparam int ILEN  = 32;
    localparam int C_LEN = 2;
    localparam int I_LEN = 4;
    function automatic logic is_compressed(input logic [1:0] lo);
        return lo != 2'b11;
    endfunction
endpackage

// File: rtl/fetch_pc_unit_pc_reg.sv
// pc_reg_p: XLEN-bit PC register; ports clk, arst (async high), we, wd -> pc
module pc_reg_p #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            we,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] pc
);
    always_ff @(posedge clk or posedge arst)
        if (arst) pc <= RESET_VECTOR;
        else if (we) pc <= wd;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner and single-outstanding imem fetch sequencer feeding decode
// ports: clk, arst | imem_req/addr/gnt/rvalid/rdata | if_valid/ready/instr/pc | redirect_*, trap_*
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            arst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc
);
    fetch_state_e    state;
    logic            discard;
    logic            redir;
    logic            pc_we;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_wd;

    assign redir = trap_valid | redirect_valid;
    assign tgt   = (trap_valid ? trap_pc : redirect_pc) & ~XLEN'(1);
    assign pc_wd = redir ? tgt : pc + XLEN'(is_compressed(if_instr[1:0]) ? C_LEN : I_LEN);
    assign pc_we = redir | (state == HOLD && if_ready);

    pc_reg_p #(.XLEN(XLEN), .RESET_VECTOR(RESET_VECTOR)) u_pc (
        .clk (clk),
        .arst(arst),
        .we  (pc_we),
        .wd  (pc_wd),
        .pc  (pc)
    );

    assign imem_req  = state == REQ;
    assign imem_addr = pc;
    assign if_valid  = state == HOLD;

    // discard marks the outstanding response as belonging to a PC that a redirect abandoned
    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            state    <= IDLE;
            discard  <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ:
                    if (imem_gnt) begin
                        state   <= WAIT;
                        discard <= redir;
                    end
                WAIT:
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (discard || redir) state <= REQ;
                        else begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            state    <= HOLD;
                        end
                    end else if (redir) discard <= 1'b1;
                HOLD: if (redir || if_ready) state <= REQ;
            endcase
        end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven fetch sequences with a response scoreboard plus redirect/reset corner cases
module tb_fetch_pc_unit;
    logic        clk = 0;
    logic        arst = 1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 0;
    logic        imem_rvalid = 0;
    logic [31:0] imem_rdata = 0;
    logic        if_valid;
    logic        if_ready = 0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        trap_valid = 0;
    logic [31:0] trap_pc = 0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          hold;
        logic        rv;
        logic [31:0] rpc;
        logic        tv;
        logic [31:0] tpc;
    } rec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    rec_t tbl[14];
    exp_t sb[$];

    fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100)) dut (
        .clk           (clk),
        .arst          (arst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8 && !imem_req; i++) step();
        chk("req_seen", {31'd0, imem_req}, 32'd1);
    endtask

    // one complete fetch: request, immediate grant, response next cycle, optional backpressure,
    // then consume with an optional redirect/trap in the consuming cycle
    task automatic fetch(input rec_t r);
        exp_t e;
        wait_req();
        chk("imem_addr", imem_addr, r.addr);
        imem_gnt = 1;
        step();
        imem_gnt = 0;
        chk("req_low_in_wait", {31'd0, imem_req}, 32'd0);
        imem_rdata  = r.data;
        imem_rvalid = 1;
        sb.push_back('{pc: r.addr, instr: r.data});
        step();
        imem_rvalid = 0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk("if_valid", {31'd0, if_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got 0 entries want 1");
            return;
        end
        e = sb.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        for (int k = 0; k < r.hold; k++) begin
            step();
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, e.pc);
            chk("hold_instr", if_instr, e.instr);
        end
        if_ready       = 1;
        redirect_valid = r.rv;
        redirect_pc    = r.rpc;
        trap_valid     = r.tv;
        trap_pc        = r.tpc;
        step();
        if_ready       = 0;
        redirect_valid = 0;
        trap_valid     = 0;
    endtask

    initial begin
        rec_t r;
        tbl[0]  = '{32'h0000_0100, 32'h0000_0013, 0, 0, 0, 0, 0};
        tbl[1]  = '{32'h0000_0104, 32'h00A0_0093, 0, 0, 0, 0, 0};
        tbl[2]  = '{32'h0000_0108, 32'h0000_0013, 0, 1, 32'h200, 0, 0};
        tbl[3]  = '{32'h0000_0200, 32'h0000_4501, 0, 0, 0, 0, 0};
        tbl[4]  = '{32'h0000_0202, 32'h0000_0013, 0, 0, 0, 0, 0};
        tbl[5]  = '{32'h0000_0206, 32'h0000_4501, 2, 1, 32'h301, 0, 0};
        tbl[6]  = '{32'h0000_0300, 32'h0000_0013, 0, 0, 0, 0, 0};
        tbl[7]  = '{32'h0000_0304, 32'h0000_8082, 0, 0, 0, 0, 0};
        tbl[8]  = '{32'h0000_0306, 32'h0000_0013, 0, 1, 32'h500, 1, 32'h800};
        tbl[9]  = '{32'h0000_0800, 32'h0000_0013, 0, 0, 0, 1, 32'hFFFF_FFFC};
        tbl[10] = '{32'hFFFF_FFFC, 32'h00A0_0093, 5, 0, 0, 0, 0};
        tbl[11] = '{32'h0000_0000, 32'h0000_0001, 0, 0, 0, 1, 32'hFFFF_FFFF};
        tbl[12] = '{32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0, 0, 0};
        tbl[13] = '{32'h0000_0000, 32'h0000_0013, 0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        arst = 0;
        step();
        chk("idle_to_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 14; i++) fetch(tbl[i]);

        // redirect while waiting: response for the old PC must not reach decode
        wait_req();
        chk("stale_addr0", imem_addr, 32'h4);
        imem_gnt = 1;
        step();
        imem_gnt       = 0;
        redirect_valid = 1;
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 0;
        chk("stale_still_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1;
        imem_rdata  = 32'h0000_0013;
        step();
        imem_rvalid = 0;
        chk("stale_valid", {31'd0, if_valid}, 32'd0);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        chk("stale_addr", imem_addr, 32'h400);

        // redirect in the same cycle as the grant
        imem_gnt       = 1;
        redirect_valid = 1;
        redirect_pc    = 32'h600;
        step();
        imem_gnt       = 0;
        redirect_valid = 0;
        chk("gntredir_wait", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1;
        step();
        imem_rvalid = 0;
        chk("gntredir_valid", {31'd0, if_valid}, 32'd0);
        chk("gntredir_addr", imem_addr, 32'h600);

        // redirect in the same cycle as the response
        imem_gnt = 1;
        step();
        imem_gnt       = 0;
        imem_rvalid    = 1;
        redirect_valid = 1;
        redirect_pc    = 32'h700;
        step();
        imem_rvalid    = 0;
        redirect_valid = 0;
        chk("rvredir_valid", {31'd0, if_valid}, 32'd0);
        chk("rvredir_req", {31'd0, imem_req}, 32'd1);
        chk("rvredir_addr", imem_addr, 32'h700);
        r = '{32'h0000_0700, 32'h0000_0013, 1, 0, 0, 0, 0};
        fetch(r);

        // reset while a response is outstanding
        wait_req();
        chk("rstw_addr0", imem_addr, 32'h704);
        imem_gnt = 1;
        step();
        imem_gnt = 0;
        #2 arst = 1;
        #1;
        chk("rstw_async_req", {31'd0, imem_req}, 32'd0);
        chk("rstw_async_addr", imem_addr, 32'h100);
        chk("rstw_async_pc", if_pc, 32'd0);
        @(posedge clk);
        #1 arst = 0;
        step();
        imem_rvalid = 1;
        imem_rdata  = 32'hCAFE_0013;
        step();
        imem_rvalid = 0;
        chk("rstw_valid", {31'd0, if_valid}, 32'd0);
        chk("rstw_req", {31'd0, imem_req}, 32'd1);
        chk("rstw_addr", imem_addr, 32'h100);
        r = '{32'h0000_0100, 32'h0000_0013, 0, 0, 0, 0, 0};
        fetch(r);
        wait_req();
        chk("post_rst_next", imem_addr, 32'h104);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter and instruction-fetch sequencer for the RV32IMC core, the successor to the plain PC register. It owns the PC, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and presents the fetched instruction and its PC to decode over a valid/ready handshake. It advances by 2 or 4 bytes based on the compressed-instruction encoding. Trap and branch/jump redirects are accepted at any point, and any in-flight response made stale by a redirect is discarded.

## Interface
- XLEN, 32: PC and instruction-memory address width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  asynchronous reset, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; equals current PC; halfword-aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; exactly one per granted request; never in the same cycle as its gnt.
- imem_rdata  in  32  32 bits starting at imem_addr; lower halfword is the instruction start.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts the instruction.
- if_instr  out  32  captured imem_rdata.
- if_pc  out  XLEN  PC of if_instr.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  XLEN  branch/jump target.
- trap_valid  in  1  trap or mret.
- trap_pc  in  XLEN  trap vector or mepc.

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- Redirect selection: trap_valid has priority over redirect_valid. The selected target has bit 0 forced to 0.
- IDLE: entered on reset. Moves to REQ on the first clock after reset deassertion.
- REQ:
  - imem_req=1.
  - On gnt with no redirect: go to WAIT.
  - On redirect without gnt: pc<=target; stay in REQ (the address changes next cycle).
  - On redirect with gnt: pc<=target; discard<=1; go to WAIT.
- WAIT:
  - imem_req=0.
  - On rvalid with discard=1: discard<=0; go to REQ.
  - On rvalid with discard=0: capture rdata into if_instr and pc into if_pc; go to HOLD.
  - On redirect without rvalid: pc<=target; discard<=1.
  - On redirect with rvalid: pc<=target; drop the response; discard<=0; go to REQ.
- HOLD:
  - if_valid=1.
  - On if_ready with no redirect: pc<=pc+len; go to REQ.
  - On redirect: pc<=target; go to REQ. This applies even if if_ready is high in the same cycle; the instruction is still consumed by decode, and redirect_pc is authoritative.
- len rule: len=2 if if_instr[1:0]!=2'b11, else len=4.
- PC arithmetic is modulo 2^XLEN. 0xFFFF_FFFE+2 and 0xFFFF_FFFC+4 both wrap to 0.
- if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- Reset mid-operation: all state returns to reset values immediately. Any later rvalid belonging to the aborted request is ignored, because the unit is in IDLE or REQ when it arrives.

## Timing
- Reset values: pc=RESET_VECTOR, state=IDLE, discard=0, imem_req=0, imem_addr=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0.
- imem_req, imem_addr and if_valid are registered-state decodes with no combinational path from any input.
- Minimum throughput:
  - Cycle n: REQ with gnt.
  - Cycle n+1: WAIT with rvalid.
  - Cycle n+2: HOLD, if_valid=1, if_ready.
  - Cycle n+3: next REQ.
  - Result: one instruction per 3 cycles.
- Redirect latency: imem_addr shows the target on the cycle after the redirect, or on the first REQ cycle after a discarded response.
- At most one request is outstanding.

## Structure
- Package fetch_pkg:
  - fetch_state_e enum (IDLE, REQ, WAIT, HOLD).
  - ILEN=32.
  - Localparam C_LEN=2 and I_LEN=4.
  - Function is_compressed(logic [1:0]).
- Sub-module pc_reg_p: parametrised XLEN-bit PC register with asynchronous active-high reset to RESET_VECTOR, a write enable and write data. All next-PC muxing lives in fetch_pc_unit.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_VECTOR=0x100. Memory returns 0x00000013 at 0x100 and 0x00A00093 at 0x104. gnt and rvalid are immediate; if_ready=1.
  - Required: imem_addr sequence 0x100, 0x104, 0x108. if_pc matches each address.
- Compressed step:
  - Stimulus: rdata=0x00004501 at 0x200.
  - Required: next imem_addr=0x202. Then rdata=0x00000013 at 0x202 gives next imem_addr=0x206.
- Stale discard:
  - Stimulus: redirect_pc=0x400 while in WAIT for 0x104.
  - Required: the response for 0x104 never raises if_valid; the next imem_addr is 0x400.
- Priority:
  - Stimulus: in HOLD, trap_valid (trap_pc=0x800), redirect_valid (0x500) and if_ready all in the same cycle.
  - Required: next imem_addr=0x800.
- Backpressure and wrap:
  - Stimulus: hold if_ready=0 for 5 cycles with if_pc=0xFFFF_FFFC and a 32-bit instruction.
  - Required: if_instr and if_pc stable throughout; after if_ready, imem_addr=0x0.
- Reset mid-WAIT:
  - Stimulus: assert arst while WAIT is outstanding, then send rvalid after release.
  - Required: if_valid stays 0, and imem_addr=RESET_VECTOR.
